fib_dispatch: RTL and testbench

- Request front-end placed directly upstream of the fibonacci core.
- Queues index requests from a producer in a small FIFO and issues them one at a time to the core using the core's start/ready/done handshake.
- Captures each result together with its index into a valid/ready result register for the downstream consumer.
- Adds a watchdog so a hung core cannot stall the pipeline.

---
 rtl/fib_dispatch.sv | 248 ++++++++++++++++++++++++
 tb/tb_fib_dispatch.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_dispatch.sv
// -----------------------------------------------------------------------------
// fib_dispatch
//
// Request front-end for the Fibonacci core. Index requests from a producer are
// queued in a small FIFO and handed to the core one at a time through its
// start/ready/done handshake. Each result is captured with its index in a
// valid/ready result register. A watchdog aborts a request whose done pulse
// never arrives, so a hung core cannot stall the pipeline.
//
// Parameters
//   IDX_W    width of the Fibonacci index
//   N        width of the Fibonacci result
//   DEPTH    request FIFO depth (power of 2, >= 2)
//   TIMEOUT  maximum cycles spent waiting for done before abort (>= 2)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   req_valid   producer has a request
//   req_ready   FIFO can accept (combinational, fifo_count < DEPTH)
//   req_idx     requested index
//   core_in     index to the core, held from start until done or abort
//   core_start  one-cycle start pulse to the core (registered)
//   core_ready  core is idle
//   core_done   one-cycle done pulse, core_fib valid in that cycle
//   core_fib    core result
//   res_valid   result register full
//   res_ready   consumer accepts the result
//   res_idx     index of the held result
//   res_fib     held result
//   res_err     held result was a timeout abort
//   fifo_count  FIFO occupancy
//   busy        dispatcher has a request in flight
// -----------------------------------------------------------------------------
module fib_dispatch #(
   parameter int IDX_W   = 5,
   parameter int N       = 10,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [IDX_W-1:0]         req_idx,
   output logic [IDX_W-1:0]         core_in,
   output logic                     core_start,
   input  logic                     core_ready,
   input  logic                     core_done,
   input  logic [N-1:0]             core_fib,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [IDX_W-1:0]         res_idx,
   output logic [N-1:0]             res_fib,
   output logic                     res_err,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t              state_r;
   state_t              state_nxt_s;

   logic [IDX_W-1:0]    mem_r [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [CNT_W-1:0]    fifo_count_r;

   logic [IDX_W-1:0]    core_in_r;
   logic                core_start_r;
   logic [WD_W-1:0]     wd_r;

   logic                res_valid_r;
   logic [IDX_W-1:0]    res_idx_r;
   logic [N-1:0]        res_fib_r;
   logic                res_err_r;

   // ---------------------------------------------------------------------------
   // Decoded events
   // ---------------------------------------------------------------------------
   logic                req_ready_s;
   logic                push_s;
   logic                issue_s;
   logic                done_s;
   logic                timeout_s;
   logic                res_accept_s;

   assign req_ready_s  = (fifo_count_r < DEPTH_C);
   assign push_s       = req_valid && req_ready_s;

   // Issue only when a request is queued, the core is idle and the previous
   // result has been consumed, so a completion never overwrites unread data.
   assign issue_s      = (state_r == IDLE) && (fifo_count_r != {CNT_W{1'b0}})
                         && core_ready && !res_valid_r;

   // A done pulse on the same edge as the timeout takes priority.
   assign done_s       = (state_r == WAIT) && core_done;
   assign timeout_s    = (state_r == WAIT) && !core_done && (wd_r == WD_LAST);
   assign res_accept_s = res_valid_r && res_ready;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (issue_s) begin
               state_nxt_s = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            state_nxt_s = WAIT;
         end
         WAIT: begin
            if (done_s || timeout_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FIFO storage and pointers; pointers wrap naturally since DEPTH is 2^PTR_W
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {IDX_W{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= req_idx;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (issue_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   // FIFO occupancy; a push and pop on the same edge leave it unchanged
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_count_r <= {CNT_W{1'b0}};
      end else begin
         case ({push_s, issue_s})
            2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1);
            2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1);
            default: fifo_count_r <= fifo_count_r;
         endcase
      end
   end

   // Core request: head of FIFO latched on issue, start pulse for one cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         core_in_r    <= {IDX_W{1'b0}};
         core_start_r <= 1'b0;
      end else begin
         if (issue_s) begin
            core_in_r <= mem_r[rd_ptr_r];
         end
         core_start_r <= issue_s;
      end
   end

   // Watchdog: zeroed in ISSUE, counts each WAIT cycle without done
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_r <= {WD_W{1'b0}};
      end else if (state_r == ISSUE) begin
         wd_r <= {WD_W{1'b0}};
      end else if ((state_r == WAIT) && !core_done && (wd_r != WD_LAST)) begin
         wd_r <= wd_r + WD_W'(1);
      end else begin
         wd_r <= wd_r;
      end
   end

   // Result register: loaded on completion or abort, cleared on acceptance.
   // In WAIT res_valid is always 0, so load and accept never coincide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid_r <= 1'b0;
         res_idx_r   <= {IDX_W{1'b0}};
         res_fib_r   <= {N{1'b0}};
         res_err_r   <= 1'b0;
      end else if (done_s) begin
         res_valid_r <= 1'b1;
         res_idx_r   <= core_in_r;
         res_fib_r   <= core_fib;
         res_err_r   <= 1'b0;
      end else if (timeout_s) begin
         res_valid_r <= 1'b1;
         res_idx_r   <= core_in_r;
         res_fib_r   <= {N{1'b0}};
         res_err_r   <= 1'b1;
      end else if (res_accept_s) begin
         res_valid_r <= 1'b0;
      end else begin
         res_valid_r <= res_valid_r;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign req_ready  = req_ready_s;
   assign core_in    = core_in_r;
   assign core_start = core_start_r;
   assign res_valid  = res_valid_r;
   assign res_idx    = res_idx_r;
   assign res_fib    = res_fib_r;
   assign res_err    = res_err_r;
   assign fifo_count = fifo_count_r;
   assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_fib_dispatch.sv
// -----------------------------------------------------------------------------
// tb_fib_dispatch
//
// Self-checking bench for fib_dispatch. A behavioural core stand-in answers
// start pulses with fib(k) mod 2^N after a random latency (or never, in hang
// mode). A scoreboard queue records every accepted request in order and checks
// each consumed result against fib() computed directly. Directed steps cover
// reset, single request, burst/full FIFO, backpressure, timeout and reset
// mid-flight, followed by a randomized request/backpressure phase.
// -----------------------------------------------------------------------------
module tb_fib_dispatch;

   localparam int IDX_W   = 5;
   localparam int N       = 10;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [IDX_W-1:0]  req_idx;
   logic [IDX_W-1:0]  core_in;
   logic              core_start;
   logic              core_ready;
   logic              core_done;
   logic [N-1:0]      core_fib;
   logic              res_valid;
   logic              res_ready;
   logic [IDX_W-1:0]  res_idx;
   logic [N-1:0]      res_fib;
   logic              res_err;
   logic [2:0]        fifo_count;
   logic              busy;

   int n_chk  = 0;
   int n_fail = 0;

   // bench controls, written only by the main initial block
   logic hang    = 1'b0;
   logic rand_rr = 1'b0;
   int   lat_min = 1;
   int   lat_max = 6;

   typedef struct {
      int   idx;
      logic err;
   } exp_t;

   exp_t exp_q[$];
   int   res_log[$];
   int   full_cnt = 0;
   logic prev_start = 1'b0;

   // core stand-in state
   logic              busy_m;
   int                cnt_m;
   logic [IDX_W-1:0]  idx_m;

   fib_dispatch #(
      .IDX_W   (IDX_W),
      .N       (N),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_idx    (req_idx),
      .core_in    (core_in),
      .core_start (core_start),
      .core_ready (core_ready),
      .core_done  (core_done),
      .core_fib   (core_fib),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_idx    (res_idx),
      .res_fib    (res_fib),
      .res_err    (res_err),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Fibonacci by direct iteration, reduced to N bits
   function automatic int fib_ref(input int k);
      int a = 0;
      int b = 1;
      int t;
      for (int i = 0; i < k; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a % (1 << N);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Core stand-in: accepts a start when idle, answers after a random latency
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         core_ready <= 1'b1;
         core_done  <= 1'b0;
         core_fib   <= '0;
         busy_m     <= 1'b0;
         cnt_m      <= 0;
         idx_m      <= '0;
      end else begin
         core_done <= 1'b0;
         if (core_start && !busy_m && !hang) begin
            idx_m      <= core_in;
            cnt_m      <= int'($urandom_range(lat_max, lat_min));
            busy_m     <= 1'b1;
            core_ready <= 1'b0;
         end else if (busy_m) begin
            if (cnt_m == 0) begin
               core_done  <= 1'b1;
               core_fib   <= N'(fib_ref(int'(idx_m)));
               busy_m     <= 1'b0;
               core_ready <= 1'b1;
            end else begin
               cnt_m <= cnt_m - 1;
            end
         end
      end
   end

   // Scoreboard and per-cycle invariants, sampled with pre-edge values
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q.delete();
         prev_start <= 1'b0;
      end else begin
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               check("res_unexpected", 32'(res_valid), 32'd0);
            end else begin
               check("sb_idx", 32'(res_idx), 32'(exp_q[0].idx));
               check("sb_fib", 32'(res_fib), exp_q[0].err ? 32'd0 : 32'(fib_ref(exp_q[0].idx)));
               check("sb_err", 32'(res_err), 32'(exp_q[0].err));
               void'(exp_q.pop_front());
            end
            res_log.push_back(int'(res_fib));
         end
         if (req_valid && req_ready) begin
            exp_q.push_back('{int'(req_idx), hang});
         end
         check("fifo_bound", 32'(fifo_count <= 3'd4), 32'd1);
         if (fifo_count == 3'd4) begin
            check("full_not_ready", 32'(req_ready), 32'd0);
            full_cnt <= full_cnt + 1;
         end
         if (prev_start) begin
            check("start_one_cycle", 32'(core_start), 32'd0);
         end
         prev_start <= core_start;
      end
   end

   task automatic tick();
      @(negedge clk);
      if (rand_rr) res_ready = 1'($urandom_range(1, 0));
   endtask

   // Present one request and hold it until the edge that accepts it
   task automatic send(input int idx);
      int n = 0;
      req_valid = 1'b1;
      req_idx   = IDX_W'(idx);
      while (!req_ready && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) check("send_timeout", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   // Wait for a result and check it; consume it if res_ready is high
   task automatic wait_res(input string tag, input int idx, input int fibv, input int err);
      int n = 0;
      while (!res_valid && n < 2000) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_idx"},   32'(res_idx),   32'(idx));
      check({tag, "_fib"},   32'(res_fib),   32'(fibv));
      check({tag, "_err"},   32'(res_err),   32'(err));
      if (res_ready) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int wc;
      int n;
      int base;
      int burst_exp[5];
      int burst_idx[5];
      burst_exp = '{2, 5, 13, 34, 89};
      burst_idx = '{3, 5, 7, 9, 11};

      // ---------------- reset held with a request pending ----------------
      rst       = 1'b0;
      req_valid = 1'b1;
      req_idx   = 5'd10;
      res_ready = 1'b1;
      repeat (25) @(negedge clk);
      check("rst_core_start", 32'(core_start), 32'd0);
      check("rst_res_valid",  32'(res_valid),  32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_req_ready",  32'(req_ready),  32'd1);
      check("rst_outs", 32'({busy, core_in, res_idx, res_fib, res_err}), 32'd0);

      // ---------------- release: request 10 accepted on next edge ----------------
      rst = 1'b1;
      @(negedge clk);
      check("acc_count", 32'(fifo_count), 32'd1);
      check("acc_start", 32'(core_start), 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      check("issue_start", 32'(core_start), 32'd1);
      check("issue_in",    32'(core_in),    32'd10);
      check("issue_count", 32'(fifo_count), 32'd0);
      @(negedge clk);
      check("wait_start", 32'(core_start), 32'd0);
      check("wait_busy",  32'(busy),       32'd1);
      wait_res("single", 10, 55, 0);

      // ---------------- burst: FIFO fills to DEPTH ----------------
      lat_min = 10;
      lat_max = 10;
      base = res_log.size();
      wc   = full_cnt;
      for (int i = 0; i < 5; i++) send(burst_idx[i]);
      n = 0;
      while (res_log.size() < base + 5 && n < 1000) begin
         tick();
         n++;
      end
      check("burst_count", 32'(res_log.size() - base), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (res_log.size() > base + i) check("burst_order", 32'(res_log[base + i]), 32'(burst_exp[i]));
      end
      check("burst_full_seen", 32'(full_cnt > wc), 32'd1);

      // ---------------- backpressure ----------------
      lat_min   = 1;
      lat_max   = 6;
      res_ready = 1'b0;
      send(6);
      send(16);
      wait_res("bp_first", 6, 8, 0);
      for (int i = 0; i < 30; i++) begin
         check("bp_hold", 32'({core_start, res_valid, res_fib, fifo_count}),
               32'({1'b0, 1'b1, 10'd8, 3'd1}));
         tick();
      end
      res_ready = 1'b1;
      tick();
      wait_res("bp_second", 16, 987, 0);

      // ---------------- timeout ----------------
      hang = 1'b1;
      send(12);
      wc = 0;
      n  = 0;
      while (!res_valid && n < 500) begin
         if (busy && !core_start) wc++;
         tick();
         n++;
      end
      check("to_wait_cycles", 32'(wc), 32'(TIMEOUT));
      check("to_busy", 32'(busy), 32'd0);
      wait_res("timeout", 12, 0, 1);
      hang = 1'b0;
      send(4);
      wait_res("after_to", 4, 3, 0);

      // ---------------- reset in WAIT with 3 queued ----------------
      lat_min = 40;
      lat_max = 40;
      send(1);
      send(2);
      send(3);
      send(4);
      n = 0;
      while (!(busy && !core_start && fifo_count == 3'd3) && n < 100) begin
         tick();
         n++;
      end
      check("mid_setup", 32'(fifo_count), 32'd3);
      #2;
      rst = 1'b0;
      #1;
      check("mid_start", 32'(core_start), 32'd0);
      check("mid_count", 32'(fifo_count), 32'd0);
      check("mid_ready", 32'(req_ready),  32'd1);
      check("mid_outs", 32'({busy, res_valid, core_in, res_idx, res_fib, res_err}), 32'd0);
      @(negedge clk);
      rst     = 1'b1;
      lat_min = 1;
      lat_max = 6;
      send(7);
      wait_res("after_rst", 7, 13, 0);

      // ---------------- randomized traffic with random backpressure ----------------
      base    = res_log.size();
      rand_rr = 1'b1;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(2, 0)) tick();
         send(int'($urandom_range(31, 0)));
      end
      n = 0;
      while ((exp_q.size() != 0 || busy || res_valid) && n < 5000) begin
         tick();
         n++;
      end
      rand_rr   = 1'b0;
      res_ready = 1'b1;
      check("rand_drained", 32'(exp_q.size()), 32'd0);
      check("rand_results", 32'(res_log.size() - base), 32'd40);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
